// File: rtl/graphite_pkg.sv
// Shared definitions for the graphite command path.
package graphite_pkg;

  localparam int CMD_WIDTH = 32;
  localparam int CMD_BYTES = 4;
  localparam int BYTE_W    = CMD_WIDTH / CMD_BYTES;

  typedef logic [1:0] cmd_byte_idx_t;

  // Assembler state doubles as the index of the next expected byte.
  typedef enum cmd_byte_idx_t {
    ST_IDLE = 2'd0,
    ST_B1   = 2'd1,
    ST_B2   = 2'd2,
    ST_B3   = 2'd3
  } asm_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// First-word-fall-through command FIFO. Head is visible on pop_data while
// not empty; push and pop in the same cycle are accepted even when full.
module cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_i,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A pop frees the head slot this cycle, so a full FIFO can still take a push.
  assign do_push  = push && (!full || do_pop);
  // Zero while empty so the output is clean after reset and on drain.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_assembler.sv
// Assembles uart bytes big-endian into 32-bit commands, queues them in a
// FWFT FIFO and streams them out valid/ready. A byte-gap timeout drops a
// partial command so the host re-synchronises on a command boundary.
module uart_cmd_assembler
  import graphite_pkg::*;
#(
  parameter int FREQ_MHZ   = 25,
  parameter int TIMEOUT_US = 1000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_i,
  output logic                 uart_rd_o,
  input  logic [7:0]           uart_data_i,
  input  logic                 uart_busy_i,
  input  logic                 uart_valid_i,
  output logic                 cmd_axis_tvalid_o,
  input  logic                 cmd_axis_tready_i,
  output logic [CMD_WIDTH-1:0] cmd_axis_tdata_o,
  output logic                 resync_o,
  output logic [7:0]           drop_count_o
);

  localparam int TO_CYCLES = FREQ_MHZ * TIMEOUT_US;
  localparam int TO_W      = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam int CW        = $clog2(FIFO_DEPTH+1);

  asm_state_t           state, state_nxt;
  logic [CMD_WIDTH-1:0] shreg;
  logic [TO_W-1:0]      to_cnt;
  logic                 accept, timeout, push;
  logic [CMD_WIDTH-1:0] push_data;
  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;

  assign accept    = uart_rd_o && uart_valid_i && !uart_busy_i;
  // An accept in the timeout cycle wins over the discard.
  assign timeout   = (state != ST_IDLE) && !accept && (to_cnt == TO_W'(TO_CYCLES-1));
  assign push      = accept && (state == ST_B3);
  assign push_data = {shreg[CMD_WIDTH-1:BYTE_W], uart_data_i};

  // Assembler state register.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state: advance on each accept, fall back to IDLE on timeout.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        ST_IDLE: state_nxt = ST_B1;
        ST_B1:   state_nxt = ST_B2;
        ST_B2:   state_nxt = ST_B3;
        default: state_nxt = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_nxt = ST_IDLE;
    end
  end

  // Byte lanes of the partial command; byte 3 goes straight to the FIFO.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      shreg <= '0;
    end else if (timeout) begin
      shreg <= '0;
    end else if (accept) begin
      case (state)
        ST_IDLE: shreg[CMD_WIDTH-1 -: BYTE_W]          <= uart_data_i;
        ST_B1:   shreg[CMD_WIDTH-BYTE_W-1 -: BYTE_W]   <= uart_data_i;
        ST_B2:   shreg[CMD_WIDTH-2*BYTE_W-1 -: BYTE_W] <= uart_data_i;
        default: shreg <= '0;
      endcase
    end
  end

  // Byte-gap counter: runs mid-command only, restarts on every accepted byte.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i)                                    to_cnt <= '0;
    else if (accept || timeout || state == ST_IDLE) to_cnt <= '0;
    else                                            to_cnt <= to_cnt + 1'b1;
  end

  // Discard pulse and saturating discard count.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      resync_o     <= 1'b0;
      drop_count_o <= '0;
    end else begin
      resync_o <= timeout;
      if (timeout && drop_count_o != 8'hFF) drop_count_o <= drop_count_o + 1'b1;
    end
  end

  // Read request: stop once a push would take the last free slot, so any
  // byte 3 accepted later is guaranteed room.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) uart_rd_o <= 1'b0;
    else         uart_rd_o <= !fifo_full && !(fifo_count == CW'(FIFO_DEPTH-1) && push);
  end

  assign cmd_axis_tvalid_o = !fifo_empty;

  cmd_fifo #(
    .WIDTH (CMD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_i   (reset_i),
    .push      (push),
    .push_data (push_data),
    .pop       (cmd_axis_tvalid_o && cmd_axis_tready_i),
    .pop_data  (cmd_axis_tdata_o),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Bench for uart_cmd_assembler: table of commands through a scoreboard plus
// hand sequences for backpressure, timeout, reset and simultaneous push/pop.
module tb_uart_cmd_assembler;

  localparam int TO = 10;  // FREQ_MHZ=1 * TIMEOUT_US=10

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        uart_rd_o;
  logic [7:0]  uart_data_i = '0;
  logic        uart_busy_i = 1'b0;
  logic        uart_valid_i = 1'b0;
  logic        cmd_axis_tvalid_o;
  logic        cmd_axis_tready_i = 1'b0;
  logic [31:0] cmd_axis_tdata_o;
  logic        resync_o;
  logic [7:0]  drop_count_o;

  uart_cmd_assembler #(.FREQ_MHZ(1), .TIMEOUT_US(10), .FIFO_DEPTH(4)) dut (
    .clk               (clk),
    .reset_i           (reset_i),
    .uart_rd_o         (uart_rd_o),
    .uart_data_i       (uart_data_i),
    .uart_busy_i       (uart_busy_i),
    .uart_valid_i      (uart_valid_i),
    .cmd_axis_tvalid_o (cmd_axis_tvalid_o),
    .cmd_axis_tready_i (cmd_axis_tready_i),
    .cmd_axis_tdata_o  (cmd_axis_tdata_o),
    .resync_o          (resync_o),
    .drop_count_o      (drop_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] bytes;  // [3] is sent first
    logic [31:0]     exp;
  } vec_t;

  vec_t        vecs [5];
  logic [31:0] sb [$];
  int          checks = 0;
  int          failures = 0;
  int          pops = 0;
  int          rs_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard pop on every handshake; resync pulse counter.
  always @(negedge clk) begin
    if (!reset_i && cmd_axis_tvalid_o && cmd_axis_tready_i) begin
      pops++;
      if (sb.size() == 0) chk("sb_unexpected_word", cmd_axis_tdata_o, 32'hxxxx_xxxx);
      else                chk("sb_word", cmd_axis_tdata_o, sb.pop_front());
    end
    if (resync_o) rs_cnt++;
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    uart_valid_i = 1'b1;
    uart_data_i  = b;
    @(negedge clk);
    while (!uart_rd_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!uart_rd_o) chk("rd_wait_timeout", {31'd0, uart_rd_o}, 32'd1);
    @(posedge clk);
    #1 uart_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    sb.push_back(w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rd"},     {31'd0, uart_rd_o}, 32'd0);
    chk({tag, "_tvalid"}, {31'd0, cmd_axis_tvalid_o}, 32'd0);
    chk({tag, "_tdata"},  cmd_axis_tdata_o, 32'd0);
    chk({tag, "_resync"}, {31'd0, resync_o}, 32'd0);
    chk({tag, "_drop"},   {24'd0, drop_count_o}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, r0;
    vecs[0].bytes = {8'h12, 8'h34, 8'h56, 8'h78}; vecs[0].exp = 32'h1234_5678;
    vecs[1].bytes = {8'h00, 8'h00, 8'h00, 8'h00}; vecs[1].exp = 32'h0000_0000;
    vecs[2].bytes = {8'hFF, 8'hFF, 8'hFF, 8'hFF}; vecs[2].exp = 32'hFFFF_FFFF;
    vecs[3].bytes = {8'h80, 8'h00, 8'h00, 8'h01}; vecs[3].exp = 32'h8000_0001;
    vecs[4].bytes = {8'hA5, 8'h5A, 8'hC3, 8'h3C}; vecs[4].exp = 32'hA55A_C33C;

    #3 chk_reset_outs("reset");
    @(posedge clk); #1 reset_i = 1'b0;
    cycles(2);
    chk("rd_after_reset", {31'd0, uart_rd_o}, 32'd1);

    // 1: single command, one-cycle tvalid right after the last accept.
    cmd_axis_tready_i = 1'b1;
    r0 = rs_cnt;
    sb.push_back(32'h1234_5678);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    chk("t1_no_early_valid", {31'd0, cmd_axis_tvalid_o}, 32'd0);
    send_byte(8'h78);
    chk("t1_tvalid", {31'd0, cmd_axis_tvalid_o}, 32'd1);
    chk("t1_tdata", cmd_axis_tdata_o, 32'h1234_5678);
    cycles(1);
    chk("t1_tvalid_one_cycle", {31'd0, cmd_axis_tvalid_o}, 32'd0);

    // Table-driven commands through the scoreboard.
    p0 = pops;
    for (int v = 0; v < 5; v++) begin
      sb.push_back(vecs[v].exp);
      for (int i = 3; i >= 0; i--) send_byte(vecs[v].bytes[i]);
    end
    cycles(3);
    chk("tbl_pop_count", pops - p0, 32'd5);
    chk("t1_no_resync", rs_cnt - r0, 32'd0);

    // 2: backpressure, FIFO fills, rd drops, then drains in order.
    cmd_axis_tready_i = 1'b0;
    p0 = pops;
    for (int w = 1; w <= 4; w++) send_word(32'hC0DE_0000 + w);
    chk("t2_rd_drop", {31'd0, uart_rd_o}, 32'd0);
    chk("t2_head_held", cmd_axis_tdata_o, 32'hC0DE_0001);
    cmd_axis_tready_i = 1'b1;
    send_word(32'hC0DE_0005);
    cycles(4);
    chk("t2_pop_count", pops - p0, 32'd5);

    // 3: partial word times out, then a clean command.
    r0 = rs_cnt;
    send_byte(8'hAA); send_byte(8'hBB);
    cycles(TO - 1);
    chk("t3_no_early_resync", {31'd0, resync_o}, 32'd0);
    cycles(1);
    chk("t3_resync", {31'd0, resync_o}, 32'd1);
    chk("t3_drop1", {24'd0, drop_count_o}, 32'd1);
    cycles(1);
    chk("t3_resync_pulse", {31'd0, resync_o}, 32'd0);
    p0 = pops;
    send_word(32'hDEAD_BEEF);
    cycles(2);
    chk("t3_pop", pops - p0, 32'd1);
    chk("t3_resync_count", rs_cnt - r0, 32'd1);

    // 4: byte accepted exactly on the timeout cycle.
    r0 = rs_cnt;
    p0 = pops;
    sb.push_back(32'h0102_0304);
    send_byte(8'h01);
    cycles(TO - 1);
    send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h04);
    cycles(2);
    chk("t4_no_resync", rs_cnt - r0, 32'd0);
    chk("t4_drop_same", {24'd0, drop_count_o}, 32'd1);
    chk("t4_pop", pops - p0, 32'd1);

    // 5a: reset mid-word takes effect without a clock edge.
    send_byte(8'h11); send_byte(8'h22);
    #2 reset_i = 1'b1;
    #1 chk_reset_outs("t5a");
    @(posedge clk); #1 reset_i = 1'b0;
    cycles(1);
    p0 = pops;
    send_word(32'h3344_5566);
    cycles(2);
    chk("t5a_pop", pops - p0, 32'd1);

    // 5b: reset with three commands queued.
    cmd_axis_tready_i = 1'b0;
    for (int w = 0; w < 3; w++) send_word(32'h7700_0000 + w);
    chk("t5b_head", cmd_axis_tdata_o, 32'h7700_0000);
    #2 reset_i = 1'b1;
    #1 chk_reset_outs("t5b");
    sb.delete();
    @(posedge clk); #1 reset_i = 1'b0;
    cmd_axis_tready_i = 1'b1;
    cycles(1);
    p0 = pops;
    send_word(32'hCAFE_F00D);
    cycles(3);
    chk("t5b_one_word", pops - p0, 32'd1);

    // 6: push and pop in the same cycle at FIFO_DEPTH-1 occupancy.
    cmd_axis_tready_i = 1'b0;
    p0 = pops;
    for (int w = 1; w <= 3; w++) send_word(32'hB000_0000 + w);
    sb.push_back(32'hB000_0004);
    send_byte(8'hB0); send_byte(8'h00); send_byte(8'h00);
    uart_valid_i = 1'b1;
    uart_data_i = 8'h04;
    cmd_axis_tready_i = 1'b1;
    @(negedge clk);
    chk("t6_rd", {31'd0, uart_rd_o}, 32'd1);
    @(posedge clk);
    #1 uart_valid_i = 1'b0;
    cmd_axis_tready_i = 1'b0;
    chk("t6_count_kept", {29'd0, dut.u_fifo.count}, 32'd3);
    chk("t6_new_head", cmd_axis_tdata_o, 32'hB000_0002);
    cmd_axis_tready_i = 1'b1;
    cycles(6);
    chk("t6_pops", pops - p0, 32'd4);

    // 6b: drop counter saturates.
    r0 = rs_cnt;
    for (int i = 0; i < 300; i++) begin
      send_byte(8'h55);
      cycles(TO + 2);
      if (i == 253) chk("drop_254", {24'd0, drop_count_o}, 32'd254);
      if (i == 254) chk("drop_255", {24'd0, drop_count_o}, 32'd255);
    end
    chk("drop_sat", {24'd0, drop_count_o}, 32'd255);
    chk("resync_300", rs_cnt - r0, 32'd300);

    cycles(2);
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
